// File: rtl/id_stage_pipe_if.sv
// ---------------------------------------------------------------------------
// id_stage_pipe_if
// Bundles the signals between the decode stage and its neighbours.
// The neighbours are fetch (IF), execute (EX) and the writeback port.
//   master : the surrounding pipeline. It drives the fetch, EX-handshake,
//            flush and writeback signals, and it receives id_ready and the
//            ID/EX register contents.
//   slave  : the decode stage itself.
// Parameters: XLEN (datapath width) and NREG (register count, power of two).
// ---------------------------------------------------------------------------
interface id_stage_pipe_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  // Fetch -> decode
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;

  // EX handshake and branch flush
  logic            ex_ready;
  logic            flush;

  // Writeback port
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;

  // ID/EX pipeline register contents
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs_data;
  logic [XLEN-1:0] ex_rt_data;
  logic [XLEN-1:0] ex_imm;
  logic [AW-1:0]   ex_rd;
  logic [5:0]      ex_func;
  logic [2:0]      ex_alu_op;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_reg_write;
  logic            ex_mem_to_reg;

  modport master (
    output if_valid, if_instr, if_pc, ex_ready, flush, wb_en, wb_addr, wb_data,
    input  id_ready, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rd,
           ex_func, ex_alu_op, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_mem_to_reg
  );

  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready, flush, wb_en, wb_addr, wb_data,
    output id_ready, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rd,
           ex_func, ex_alu_op, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_mem_to_reg
  );
endinterface

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
// Parametrised instruction-decode stage of the MUSA core.
// It contains a register file with write-through bypass, the control decode,
// sign extension of the immediate, and the ID/EX pipeline register.
// It also provides a load-use interlock, EX backpressure and branch flush.
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous, active-low reset
//   bus         : slave side of id_stage_pipe_if, which carries the fetch,
//                 EX, flush and writeback signals and the ID/EX outputs
//   stall_count : saturating count of load-use bubbles inserted
// ---------------------------------------------------------------------------
module id_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int STALL_CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  id_stage_pipe_if.slave      bus,
  output logic [STALL_CW-1:0] stall_count
);
  localparam int AW = $clog2(NREG);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  logic [5:0]      opcode;
  logic [AW-1:0]   rs_addr, rt_addr, rd_addr;
  logic [XLEN-1:0] rs_data, rt_data, imm_ext;

  // Register fields are truncated to the low AW bits, so a small register
  // file aliases the upper register names onto the lower ones.
  assign opcode  = bus.if_instr[31:26];
  assign rs_addr = bus.if_instr[21 +: AW];
  assign rt_addr = bus.if_instr[16 +: AW];
  assign rd_addr = bus.if_instr[11 +: AW];
  assign imm_ext = XLEN'($signed(bus.if_instr[15:0]));

  // Shamt bits, and the register-field bits above AW, are never used.
  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.if_instr[25:6];

  // ---------------- Register file ----------------
  logic [XLEN-1:0] regs [NREG];

  // NOTE: the array is cleared by reset. A register read after reset must
  // return 0, so this reset is part of the architecture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != '0) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Read ports. Register 0 always reads 0. A writeback to the same address
  // in the same cycle is forwarded to the read port.
  // NOTE: every variable written here is given a value before any
  // conditional assignment, so no latch is inferred.
  always_comb begin
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
    if (rs_addr == '0)                                rs_data = '0;
    else if (bus.wb_en && bus.wb_addr == rs_addr)     rs_data = bus.wb_data;
    if (rt_addr == '0)                                rt_data = '0;
    else if (bus.wb_en && bus.wb_addr == rt_addr)     rt_data = bus.wb_data;
  end

  // ---------------- Control decode ----------------
  logic          dec_mem_read, dec_mem_write, dec_reg_write, dec_mem_to_reg;
  logic [2:0]    dec_alu_op;
  logic [AW-1:0] dec_dest;

  always_comb begin
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_op     = 3'b000;
    dec_dest       = '0;
    case (opcode)
      OP_RTYPE: begin
        dec_reg_write = 1'b1;
        dec_dest      = rd_addr;
        dec_alu_op    = 3'b010;
      end
      OP_ADDI: begin
        dec_reg_write = 1'b1;
        dec_dest      = rt_addr;
      end
      OP_LW: begin
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_reg_write  = 1'b1;
        dec_dest       = rt_addr;
      end
      OP_SW:   dec_mem_write = 1'b1;
      OP_BEQ:  dec_alu_op    = 3'b001;
      default: ;  // unknown opcode passes as a valid NOP
    endcase
  end

  // ---------------- Hazard and readiness ----------------
  // The rt field is a source operand only for R-type, sw and beq.
  // For addi and lw, rt is the destination.
  logic rt_is_src, load_use;
  assign rt_is_src = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  assign load_use  = bus.ex_valid && bus.ex_mem_read && (bus.ex_rd != '0) && bus.if_valid &&
                     ((bus.ex_rd == rs_addr) || ((bus.ex_rd == rt_addr) && rt_is_src));

  assign bus.id_ready = rst && (bus.flush || (bus.ex_ready && !load_use));

  // ---------------- ID/EX register ----------------
  // The priority is reset, then flush, then hold, then bubble, then load.
  // NOTE: sequential state uses non-blocking assignments. Then every
  // register samples the values from before the edge, whatever order the
  // assignments are written in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.ex_valid      <= 1'b0;
      bus.ex_pc         <= '0;
      bus.ex_rs_data    <= '0;
      bus.ex_rt_data    <= '0;
      bus.ex_imm        <= '0;
      bus.ex_rd         <= '0;
      bus.ex_func       <= '0;
      bus.ex_alu_op     <= '0;
      bus.ex_mem_read   <= 1'b0;
      bus.ex_mem_write  <= 1'b0;
      bus.ex_reg_write  <= 1'b0;
      bus.ex_mem_to_reg <= 1'b0;
      stall_count       <= '0;
    end else if (bus.flush) begin
      bus.ex_valid <= 1'b0;
    end else if (bus.ex_ready) begin
      if (load_use) begin
        // Insert a bubble. Its ex_mem_read is still 1, but it is gated off
        // by ex_valid=0, so the dependent instruction issues next cycle.
        bus.ex_valid <= 1'b0;
        if (stall_count != '1) stall_count <= stall_count + STALL_CW'(1);
      end else begin
        bus.ex_valid      <= bus.if_valid;
        bus.ex_pc         <= bus.if_pc;
        bus.ex_rs_data    <= rs_data;
        bus.ex_rt_data    <= rt_data;
        bus.ex_imm        <= imm_ext;
        bus.ex_rd         <= dec_dest;
        bus.ex_func       <= bus.if_instr[5:0];
        bus.ex_alu_op     <= dec_alu_op;
        bus.ex_mem_read   <= dec_mem_read;
        bus.ex_mem_write  <= dec_mem_write;
        bus.ex_reg_write  <= dec_reg_write;
        bus.ex_mem_to_reg <= dec_mem_to_reg;
      end
    end
  end
endmodule

// File: tb/tb_id_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_stage_pipe
// Testbench for id_stage_pipe. It uses two instances:
//   dut   : default parameters (XLEN=32, NREG=32, STALL_CW=16)
//   p_dut : NREG=8 and STALL_CW=2, for address aliasing and saturation
// ---------------------------------------------------------------------------
module tb_id_stage_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] stall_count;
  logic [1:0]  p_stall_count;

  id_stage_pipe_if #(.XLEN(32), .NREG(32)) bus ();
  id_stage_pipe_if #(.XLEN(32), .NREG(8))  pbus ();

  id_stage_pipe #(.XLEN(32), .NREG(32), .STALL_CW(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .stall_count(stall_count)
  );
  id_stage_pipe #(.XLEN(32), .NREG(8), .STALL_CW(2)) p_dut (
    .clk(clk), .rst(rst), .bus(pbus.slave), .stall_count(p_stall_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic er, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    bus.if_valid = v;  bus.if_instr = instr; bus.if_pc = pc;
    bus.ex_ready = er; bus.flush = fl;
    bus.wb_en = we;    bus.wb_addr = wa;     bus.wb_data = wd;
  endtask

  task automatic drive_p(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic we, input logic [2:0] wa, input logic [31:0] wd);
    pbus.if_valid = v;  pbus.if_instr = instr; pbus.if_pc = pc;
    pbus.ex_ready = 1'b1; pbus.flush = 1'b0;
    pbus.wb_en = we;    pbus.wb_addr = wa;     pbus.wb_data = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One row of the main table. ex_ready=1 and flush=0 for every row.
  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
    logic [31:0] exp_imm;
    logic [4:0]  exp_rd;
    logic [2:0]  exp_alu;
    logic [3:0]  exp_ctrl;   // {mem_read, mem_write, reg_write, mem_to_reg}
    logic [15:0] exp_stall;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] instr, input logic valid,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic rdy, input logic ev,
                              input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                              input logic [4:0] rd, input logic [2:0] alu, input logic [3:0] ctrl,
                              input logic [15:0] st);
    vec_t v;
    v.instr = instr; v.valid = valid; v.wb_en = we; v.wb_addr = wa; v.wb_data = wd;
    v.exp_ready = rdy; v.exp_valid = ev; v.exp_rs = rs; v.exp_rt = rt; v.exp_imm = imm;
    v.exp_rd = rd; v.exp_alu = alu; v.exp_ctrl = ctrl; v.exp_stall = st;
    return v;
  endfunction

  vec_t vecs [17];

  function automatic logic [3:0] ctrl_of_dut();
    return {bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write, bus.ex_mem_to_reg};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] instr;

    // ---- Table: register state evolves through the rows ----
    vecs[0]  = mk(i_type(6'h08, 1, 5, 16'hFFFC), 1, 1, 5'd1, 32'h1111_1111,
                  1, 1, 32'h1111_1111, 32'h0, 32'hFFFF_FFFC, 5'd5, 3'b000, 4'b0010, 16'd0);
    vecs[1]  = mk(r_type(1, 2, 3, 6'h20), 1, 1, 5'd2, 32'h22,
                  1, 1, 32'h1111_1111, 32'h22, 32'h0000_1820, 5'd3, 3'b010, 4'b0010, 16'd0);
    vecs[2]  = mk(i_type(6'h2B, 0, 2, 16'h0008), 1, 1, 5'd0, 32'hFFFF_FFFF,
                  1, 1, 32'h0, 32'h22, 32'h8, 5'd0, 3'b000, 4'b0100, 16'd0);
    vecs[3]  = mk(i_type(6'h04, 1, 2, 16'hFFFF), 1, 1, 5'd1, 32'hAAAA_0000,
                  1, 1, 32'hAAAA_0000, 32'h22, 32'hFFFF_FFFF, 5'd0, 3'b001, 4'b0000, 16'd0);
    vecs[4]  = mk(i_type(6'h3F, 2, 1, 16'h8000), 1, 0, 5'd0, 32'h0,
                  1, 1, 32'h22, 32'hAAAA_0000, 32'hFFFF_8000, 5'd0, 3'b000, 4'b0000, 16'd0);
    vecs[5]  = mk(i_type(6'h08, 1, 1, 16'h0001), 0, 0, 5'd0, 32'h0,
                  1, 0, 32'h0, 32'h0, 32'h0, 5'd0, 3'b000, 4'b0000, 16'd0);
    vecs[6]  = mk(i_type(6'h23, 3, 6, 16'h0004), 1, 1, 5'd3, 32'h300,
                  1, 1, 32'h300, 32'h0, 32'h4, 5'd6, 3'b000, 4'b1011, 16'd0);
    vecs[7]  = mk(r_type(6, 0, 7, 6'h20), 1, 0, 5'd0, 32'h0,
                  0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 3'b000, 4'b0000, 16'd1);
    vecs[8]  = mk(r_type(6, 0, 7, 6'h20), 1, 1, 5'd6, 32'h66,
                  1, 1, 32'h66, 32'h0, 32'h0000_3820, 5'd7, 3'b010, 4'b0010, 16'd1);
    vecs[9]  = mk(i_type(6'h23, 7, 0, 16'h0000), 1, 1, 5'd7, 32'h77,
                  1, 1, 32'h77, 32'h0, 32'h0, 5'd0, 3'b000, 4'b1011, 16'd1);
    vecs[10] = mk(r_type(0, 0, 1, 6'h20), 1, 0, 5'd0, 32'h0,
                  1, 1, 32'h0, 32'h0, 32'h0000_0820, 5'd1, 3'b010, 4'b0010, 16'd1);
    vecs[11] = mk(i_type(6'h23, 0, 4, 16'h0000), 1, 0, 5'd0, 32'h0,
                  1, 1, 32'h0, 32'h0, 32'h0, 5'd4, 3'b000, 4'b1011, 16'd1);
    vecs[12] = mk(i_type(6'h08, 0, 4, 16'h0005), 1, 0, 5'd0, 32'h0,
                  1, 1, 32'h0, 32'h0, 32'h5, 5'd4, 3'b000, 4'b0010, 16'd1);
    vecs[13] = mk(i_type(6'h23, 0, 5, 16'h0000), 1, 0, 5'd0, 32'h0,
                  1, 1, 32'h0, 32'h0, 32'h0, 5'd5, 3'b000, 4'b1011, 16'd1);
    vecs[14] = mk(i_type(6'h2B, 0, 5, 16'h0000), 1, 0, 5'd0, 32'h0,
                  0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 3'b000, 4'b0000, 16'd2);
    vecs[15] = mk(i_type(6'h2B, 0, 5, 16'h0000), 1, 1, 5'd5, 32'h55,
                  1, 1, 32'h0, 32'h55, 32'h0, 5'd0, 3'b000, 4'b0100, 16'd2);
    vecs[16] = mk(r_type(3, 3, 4, 6'h20), 1, 1, 5'd3, 32'hDEAD_BEEF,
                  1, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_2020, 5'd4, 3'b010, 4'b0010, 16'd2);

    // ---- Power-on reset; flush=1 shows that reset still gates id_ready ----
    rst = 1'b0;
    drive(1, r_type(1, 1, 1, 6'h20), 32'h0, 1, 1, 0, 5'd0, 32'h0);
    drive_p(0, 32'h0, 32'h0, 0, 3'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset id_ready", bus.id_ready, 1'b0);
    check("reset ex_valid", bus.ex_valid, 1'b0);
    check("reset stall_count", stall_count, 16'd0);
    check("reset ex_pc", bus.ex_pc, 32'h0);
    check("reset p ex_valid", pbus.ex_valid, 1'b0);
    rst = 1'b1;
    drive(0, 32'h0, 32'h0, 1, 0, 0, 5'd0, 32'h0);

    // ---- NREG=8 / STALL_CW=2 instance ----
    drive_p(0, 32'h0, 32'h0, 1, 3'd1, 32'h0BAD_F00D);
    tick();
    drive_p(1, r_type(9, 0, 10, 6'h20), 32'h50, 0, 3'd0, 32'h0);
    tick();
    check("p alias ex_valid", pbus.ex_valid, 1'b1);
    check("p alias r9->r1 data", pbus.ex_rs_data, 32'h0BAD_F00D);
    check("p alias rd r10->2", pbus.ex_rd, 3'd2);
    for (int k = 1; k <= 5; k++) begin
      drive_p(1, i_type(6'h23, 0, 2, 16'h0), 32'h60, 0, 3'd0, 32'h0);
      tick();
      drive_p(1, r_type(2, 0, 3, 6'h20), 32'h64, 0, 3'd0, 32'h0);
      @(negedge clk);
      check($sformatf("p bubble%0d id_ready", k), pbus.id_ready, 1'b0);
      tick();
      check($sformatf("p bubble%0d ex_valid", k), pbus.ex_valid, 1'b0);
      check($sformatf("p bubble%0d stall_count", k), p_stall_count, (k > 3) ? 2'd3 : 2'(k));
      tick();
      check($sformatf("p bubble%0d issue", k), pbus.ex_valid, 1'b1);
    end
    drive_p(0, 32'h0, 32'h0, 0, 3'd0, 32'h0);

    // ---- Table-driven main sequence ----
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].valid, vecs[i].instr, 32'h1000 + 32'(4 * i), 1, 0,
            vecs[i].wb_en, vecs[i].wb_addr, vecs[i].wb_data);
      @(negedge clk);
      check($sformatf("v%0d id_ready", i), bus.id_ready, vecs[i].exp_ready);
      tick();
      check($sformatf("v%0d ex_valid", i), bus.ex_valid, vecs[i].exp_valid);
      check($sformatf("v%0d stall_count", i), stall_count, vecs[i].exp_stall);
      if (vecs[i].exp_valid) begin
        instr = vecs[i].instr;
        check($sformatf("v%0d ex_pc", i), bus.ex_pc, 32'h1000 + 32'(4 * i));
        check($sformatf("v%0d ex_rs_data", i), bus.ex_rs_data, vecs[i].exp_rs);
        check($sformatf("v%0d ex_rt_data", i), bus.ex_rt_data, vecs[i].exp_rt);
        check($sformatf("v%0d ex_imm", i), bus.ex_imm, vecs[i].exp_imm);
        check($sformatf("v%0d ex_rd", i), bus.ex_rd, vecs[i].exp_rd);
        check($sformatf("v%0d ex_func", i), bus.ex_func, instr[5:0]);
        check($sformatf("v%0d ex_alu_op", i), bus.ex_alu_op, vecs[i].exp_alu);
        check($sformatf("v%0d ctrl", i), ctrl_of_dut(), vecs[i].exp_ctrl);
      end
    end

    // ---- Backpressure: sw held in ID/EX for three cycles ----
    drive(1, i_type(6'h2B, 1, 3, 16'h0010), 32'h200, 1, 0, 0, 5'd0, 32'h0);
    tick();
    check("bp sw ex_rs_data", bus.ex_rs_data, 32'hAAAA_0000);
    check("bp sw ex_mem_write", bus.ex_mem_write, 1'b1);
    drive(1, i_type(6'h08, 0, 8, 16'h0007), 32'h204, 0, 0, 0, 5'd0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d id_ready", c), bus.id_ready, 1'b0);
      tick();
      check($sformatf("bp%0d ex_pc", c), bus.ex_pc, 32'h200);
      check($sformatf("bp%0d ex_rt_data", c), bus.ex_rt_data, 32'hDEAD_BEEF);
      check($sformatf("bp%0d ex_imm", c), bus.ex_imm, 32'h10);
      check($sformatf("bp%0d ctrl", c), ctrl_of_dut(), 4'b0100);
      check($sformatf("bp%0d ex_valid", c), bus.ex_valid, 1'b1);
    end
    bus.ex_ready = 1'b1;
    @(negedge clk);
    check("bp release id_ready", bus.id_ready, 1'b1);
    tick();
    check("bp release ex_pc", bus.ex_pc, 32'h204);
    check("bp release ex_rd", bus.ex_rd, 5'd8);
    check("bp release ctrl", ctrl_of_dut(), 4'b0010);

    // ---- Flush overrides load_use and ex_ready=0 ----
    drive(1, i_type(6'h23, 0, 2, 16'h0), 32'h300, 1, 0, 0, 5'd0, 32'h0);
    tick();
    drive(1, r_type(2, 1, 3, 6'h20), 32'h304, 0, 0, 0, 5'd0, 32'h0);
    #2;
    check("flush pre id_ready", bus.id_ready, 1'b0);
    bus.flush = 1'b1;
    #1;
    check("flush id_ready", bus.id_ready, 1'b1);
    tick();
    check("flush ex_valid", bus.ex_valid, 1'b0);
    check("flush stall_count", stall_count, 16'd2);
    drive(1, r_type(2, 1, 3, 6'h20), 32'h304, 1, 0, 0, 5'd0, 32'h0);
    @(negedge clk);
    check("post-flush id_ready", bus.id_ready, 1'b1);
    tick();
    check("post-flush ex_valid", bus.ex_valid, 1'b1);
    check("post-flush ex_rs_data", bus.ex_rs_data, 32'h22);

    // ---- Reset clears the register file and the ID/EX register ----
    drive(1, i_type(6'h08, 5, 9, 16'h0001), 32'h3F0, 1, 0, 1, 5'd5, 32'h1234);
    tick();
    check("pre-reset ex_valid", bus.ex_valid, 1'b1);
    check("pre-reset r5 bypass", bus.ex_rs_data, 32'h1234);
    rst = 1'b0;
    drive(1, r_type(6, 0, 7, 6'h20), 32'h3F4, 1, 0, 0, 5'd0, 32'h0);
    @(negedge clk);
    check("mid reset id_ready", bus.id_ready, 1'b0);
    tick();
    check("after reset ex_valid", bus.ex_valid, 1'b0);
    check("after reset stall_count", stall_count, 16'd0);
    check("after reset ex_rs_data", bus.ex_rs_data, 32'h0);
    rst = 1'b1;
    drive(1, r_type(5, 5, 6, 6'h20), 32'h400, 1, 0, 0, 5'd0, 32'h0);
    tick();
    check("post-reset add ex_valid", bus.ex_valid, 1'b1);
    check("post-reset r5 rs", bus.ex_rs_data, 32'h0);
    check("post-reset r5 rt", bus.ex_rt_data, 32'h0);
    check("post-reset ex_rd", bus.ex_rd, 5'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
